// File: rtl/matrix_operand_store_if.sv
// matrix_operand_store_if: host and multiplier-facing signals of the operand store
interface matrix_operand_store_if;
  logic host_start, ld_we, ld_sel;
  logic [4:0] ld_row, ld_col, rd_row, rd_col;
  logic [31:0] ld_data, rd_data;
  logic busy, complete, err, mm_start;
  logic [4:0] a_i, a_j, b_i, b_j, z_i, z_j;
  logic [31:0] a_in, b_in, z_out;
  logic z_stb, z_ack, mm_done;
  modport master(
    output host_start, ld_we, ld_sel, ld_row, ld_col, ld_data, rd_row, rd_col,
    output a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, mm_done,
    input rd_data, busy, complete, err, mm_start, a_in, b_in, z_ack
  );
  modport slave(
    input host_start, ld_we, ld_sel, ld_row, ld_col, ld_data, rd_row, rd_col,
    input a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, mm_done,
    output rd_data, busy, complete, err, mm_start, a_in, b_in, z_ack
  );
endinterface

// File: rtl/matrix_operand_store.sv
// matrix_operand_store: operand A/B store and result C capture for a sequential matrix multiplier
module matrix_operand_store #(
  parameter int m = 4
) (
  input logic clk,
  input logic rst,
  matrix_operand_store_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;
  localparam int iw = m > 1 ? $clog2(m) : 1;
  localparam logic [15:0] total = 16'(m * m * m);
  state_t state, state_n;
  logic [31:0] a_mem [m][m];
  logic [31:0] b_mem [m][m];
  logic [31:0] c_mem [m][m];
  logic [31:0] rd_q;
  logic [15:0] hs_cnt, hs_next;
  logic ack_pend, z_ack_q, complete_q, err_q, capture, err_set;
  function automatic logic in_rng(input logic [4:0] r, input logic [4:0] c);
    return r < 5'(m) && c < 5'(m);
  endfunction
  always_comb begin
    state_n = state;
    capture = 1'b0;
    hs_next = hs_cnt;
    err_set = 1'b0;
    state_n = state == S_IDLE ? (bus.host_start ? S_START : S_IDLE) :
              state == S_START ? S_RUN : (bus.mm_done ? S_IDLE : S_RUN);
    capture = state == S_RUN && bus.z_stb && !ack_pend && !z_ack_q;
    hs_next = capture && hs_cnt != 16'hFFFF ? hs_cnt + 16'd1 : hs_cnt;
    // a strobe coinciding with done is counted before the count is judged
    err_set = (bus.ld_we && state != S_IDLE) ||
              (capture && !in_rng(bus.z_i, bus.z_j)) ||
              (bus.z_stb && state != S_RUN) ||
              (state == S_RUN && bus.mm_done && hs_next != total);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ack_pend <= 1'b0;
      hs_cnt <= '0;
      err_q <= 1'b0;
      z_ack_q <= 1'b0;
      complete_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state <= state_n;
      ack_pend <= capture || (ack_pend && bus.z_stb);
      hs_cnt <= state == S_START ? '0 : hs_next;
      err_q <= state == S_IDLE && bus.host_start ? 1'b0 : err_q || err_set;
      z_ack_q <= capture;
      complete_q <= state == S_RUN && bus.mm_done;
      rd_q <= in_rng(bus.rd_row, bus.rd_col) ? c_mem[bus.rd_row[iw-1:0]][bus.rd_col[iw-1:0]] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || state == S_START) begin
      for (int r = 0; r < m; r++)
        for (int c = 0; c < m; c++)
          c_mem[r][c] <= '0;
    end else if (capture && in_rng(bus.z_i, bus.z_j)) begin
      c_mem[bus.z_i[iw-1:0]][bus.z_j[iw-1:0]] <= bus.z_out;
    end
  end
  // operands survive reset so a host can rerun without reloading
  always_ff @(posedge clk) begin
    if (!rst && bus.ld_we && state == S_IDLE && in_rng(bus.ld_row, bus.ld_col)) begin
      if (bus.ld_sel) b_mem[bus.ld_row[iw-1:0]][bus.ld_col[iw-1:0]] <= bus.ld_data;
      else a_mem[bus.ld_row[iw-1:0]][bus.ld_col[iw-1:0]] <= bus.ld_data;
    end
  end
  assign bus.a_in = in_rng(bus.a_i, bus.a_j) ? a_mem[bus.a_i[iw-1:0]][bus.a_j[iw-1:0]] : '0;
  assign bus.b_in = in_rng(bus.b_i, bus.b_j) ? b_mem[bus.b_i[iw-1:0]][bus.b_j[iw-1:0]] : '0;
  assign bus.rd_data = rd_q;
  assign bus.busy = state == S_RUN;
  assign bus.mm_start = state == S_START;
  assign bus.complete = complete_q;
  assign bus.err = err_q;
  assign bus.z_ack = z_ack_q;
endmodule

// File: doc/matrix_operand_store.md
# matrix_operand_store

Responder-side companion to `sequential_matrix_multiplier`. It holds operand matrices A and B loaded by a host and serves their elements combinationally on the multiplier's index outputs. It captures every `z_out` strobe into result matrix C through the `z_stb`/`z_ack` handshake, and exposes C to the host for readback once the multiplier reports `done`. Data words are IEEE-754 single precision; this block never interprets them.

## Interface
Parameters:
- `m`, default 4: matrix dimension. Legal range is 1..31, limited by the 5-bit indices.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `host_start` in 1: request a multiplication.
- `ld_we` in 1: operand write strobe.
- `ld_sel` in 1: operand select, 0 = A, 1 = B.
- `ld_row`, `ld_col` in 5: operand write index.
- `ld_data` in 32: operand write data.
- `rd_row`, `rd_col` in 5: C readback index.
- `rd_data` out 32: C[rd_row][rd_col], registered.
- `busy` out 1: a run is in progress.
- `complete` out 1: one-cycle pulse at the end of a run.
- `err` out 1: sticky protocol-error flag.
- `mm_start` out 1: start output to the multiplier.
- `a_i`, `a_j`, `b_i`, `b_j` in 5: indices from the multiplier.
- `a_in`, `b_in` out 32: operand data to the multiplier.
- `z_out` in 32: result data from the multiplier.
- `z_i`, `z_j` in 5: result index from the multiplier.
- `z_stb` in 1: result strobe from the multiplier.
- `z_ack` out 1: result acknowledge to the multiplier.
- `mm_done` in 1: done indication from the multiplier.

## Operation
- **Operand storage.** A and B are m×m arrays of 32-bit words and are not cleared by reset.
  - A write to A or B occurs when `ld_we` is high, the state is S_IDLE, and both `ld_row` and `ld_col` are < m.
  - Any other `ld_we` is ignored. If the drop happens because the state is not S_IDLE, set `err`.
- **Operand serving.** Reads are combinational and valid in every state.
  - `a_in` = A[a_i][a_j] and `b_in` = B[b_i][b_j].
  - An index ≥ m returns 32'h0.
- **Result storage.** C is an m×m array. It is cleared to 0 by `rst` and on entry to S_START.
- **States:**
  - S_IDLE: `busy` = 0. If `host_start` is high, go to S_START.
  - S_START: `mm_start` = 1 for this cycle only. Clear C, clear the handshake counter `hs_cnt` (16 bits), then go to S_RUN.
  - S_RUN: `busy` = 1. Perform result capture, below. When `mm_done` is seen high, go to S_IDLE and pulse `complete` for one cycle. If `hs_cnt` ≠ m³ at that moment, set `err`.
- **Result capture** (S_RUN only):
  - Condition: `z_stb` is high, `ack_pend` is 0, and `z_ack` is 0.
  - On that cycle: write C[z_i][z_j] ← `z_out` (dropped with `err` set if either index ≥ m), assert `z_ack` for exactly one cycle, set `ack_pend`, and increment `hs_cnt` (saturating at 16'hFFFF).
  - `ack_pend` clears on the first cycle `z_stb` is sampled low. This gives one acknowledge per strobe.
  - Partial sums overwrite the same C entry; the value written at k = m−1 stands last, so C ends holding the final sum.
- **Outside S_RUN.** A `z_stb` is never acknowledged outside S_RUN and sets `err`.
- **Reset priority.** `rst` has priority over all activity, including mid-run.
  - State, `ack_pend`, `hs_cnt`, `err`, and C clear; A and B keep their contents.
  - The multiplier is reset by the same `rst`.
- **Start while busy.** `host_start` during S_START or S_RUN is ignored.
- **`err` clearing.** `err` clears only on `rst`, or on entry to S_START.

## Timing
- **Reset values:** `mm_start` = 0, `z_ack` = 0, `busy` = 0, `complete` = 0, `err` = 0, `rd_data` = 0.
- **Start path:** `host_start` sampled in cycle t gives `mm_start` high in cycle t+1, and `busy` high from cycle t+2.
- **Acknowledge latency:** `z_stb` first sampled high in cycle t gives `z_ack` high during t+1 and low at t+2. The C write occurs at the end of cycle t.
- **Readback:** `rd_data` has one-cycle latency and a value of 0 for out-of-range indices. A C entry is readable one cycle after it is written.
- **Completion:** `mm_done` sampled in cycle t gives `complete` high and `busy` low in cycle t+1.
- **Simultaneous events:**
  - `host_start` together with `ld_we` in S_IDLE: the write commits and the run starts.
  - `z_stb` together with `mm_done`: the capture completes first, and this capture is counted.

## Test plan
- **Identity times B.** Load A = I with 1.0 = 32'h3F800000; load B[r][c] = 32'h40000000 (2.0) for every r, c; run. Required: every C entry = 32'h40000000, `hs_cnt` = 64, `err` = 0, `complete` pulses once.
- **Handshake pacing.** Hold `z_stb` high for 5 cycles. Required: exactly one `z_ack` pulse, at t+1, and one C write; a second `z_stb` after a low cycle gives a second ack.
- **Load and start during a run.** Issue `ld_we` to A[0][0] during S_RUN. Required: A is unchanged and `err` = 1. A `host_start` during S_RUN gives no second `mm_start`.
- **Out of range.** With m = 4: an A read with `a_i` = 5 returns 0; a `z_stb` with `z_i` = 4 is acked, leaves C unchanged, and sets `err`.
- **Reset mid-run.** Assert `rst` after 10 handshakes. Required: `busy` = 0, all C = 0, and A/B retained; a following run completes correctly.
- **Early done.** Assert `mm_done` after 3 handshakes. Required: `complete` pulses and `err` = 1.
